// File: rtl/wb_regfile.sv
// MEM/WB stage register feeding a 2**ADDR_W-entry register file with two combinational read ports.
// Define WB_REGFILE_BYPASS_EN to make a read of the index being written return the new value in that same cycle.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_reg_write,
  input  logic              i_mem_to_reg,
  input  logic [ADDR_W-1:0] i_dest_reg,
  input  logic [DATA_W-1:0] i_alu_result,
  input  logic [DATA_W-1:0] i_mem_data,
  input  logic [ADDR_W-1:0] i_rs_addr,
  input  logic [ADDR_W-1:0] i_rt_addr,
  output logic [DATA_W-1:0] o_rs_data,
  output logic [DATA_W-1:0] o_rt_data,
  output logic              o_wb_we,
  output logic [ADDR_W-1:0] o_wb_dest,
  output logic [DATA_W-1:0] o_wb_data
);

  localparam int NREG = 1 << ADDR_W;

  logic              wb_we_q, wb_we_d;
  logic [ADDR_W-1:0] wb_dest_q, wb_dest_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [DATA_W-1:0] regs_q [NREG];

  // A write to index 0 is dropped here, so the array never sees one.
  always_comb begin
    wb_we_d   = i_reg_write & (i_dest_reg != '0);
    wb_dest_d = i_dest_reg;
    wb_data_d = i_mem_to_reg ? i_mem_data : i_alu_result;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wb_we_q   <= 1'b0;
      wb_dest_q <= '0;
      wb_data_q <= '0;
    end else begin
      wb_we_q   <= wb_we_d;
      wb_dest_q <= wb_dest_d;
      wb_data_q <= wb_data_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wb_we_q) begin
      regs_q[wb_dest_q] <= wb_data_q;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] val;
    if (addr == '0) begin
      val = '0;
    end else begin
      val = regs_q[addr];
`ifdef WB_REGFILE_BYPASS_EN
      if (wb_we_q && (wb_dest_q == addr)) val = wb_data_q;
`endif
    end
    return val;
  endfunction

  always_comb begin
    o_rs_data = read_port(i_rs_addr);
    o_rt_data = read_port(i_rt_addr);
  end

  assign o_wb_we   = wb_we_q;
  assign o_wb_dest = wb_dest_q;
  assign o_wb_data = wb_data_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against an array-and-pending-write model.
module tb_wb_regfile;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int N  = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          reg_write = 1'b0, mem_to_reg = 1'b0;
  logic [AW-1:0] dest = '0, rs = '0, rt = '0;
  logic [DW-1:0] alu = '0, mem = '0;
  logic [DW-1:0] rs_data, rt_data, wb_data;
  logic          wb_we;
  logic [AW-1:0] wb_dest;

  wb_regfile #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_reg_write(reg_write), .i_mem_to_reg(mem_to_reg),
    .i_dest_reg(dest), .i_alu_result(alu), .i_mem_data(mem),
    .i_rs_addr(rs), .i_rt_addr(rt), .o_rs_data(rs_data), .o_rt_data(rt_data),
    .o_wb_we(wb_we), .o_wb_dest(wb_dest), .o_wb_data(wb_data)
  );

  always #5 clk = ~clk;

`ifdef WB_REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  // Reference: architectural register contents plus one pending writeback.
  logic [DW-1:0] m_arr [N];
  logic          m_we;
  logic [AW-1:0] m_dest;
  logic [DW-1:0] m_data;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) m_arr[i] <= '0;
      m_we   <= 1'b0;
      m_dest <= '0;
      m_data <= '0;
    end else begin
      if (m_we && m_dest != 0) m_arr[m_dest] <= m_data;
      m_we   <= reg_write && (dest != 0);
      m_dest <= dest;
      m_data <= mem_to_reg ? mem : alu;
    end
  end

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (BYPASS && m_we && m_dest == a) return m_data;
    return m_arr[a];
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      check("model_rs", rs_data, exp_rd(rs));
      check("model_rt", rt_data, exp_rd(rt));
      check("model_wb_we", {31'b0, wb_we}, {31'b0, m_we});
      check("model_wb_dest", {27'b0, wb_dest}, {27'b0, m_dest});
      check("model_wb_data", wb_data, m_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] v;
    #2 rst_n = 1'b0;
    #10;
    for (int i = 0; i < N; i++) begin
      rs = i[AW-1:0];
      rt = AW'(N - 1 - i);
      #1;
      check("reset_rs_zero", rs_data, 32'h0);
      check("reset_rt_zero", rt_data, 32'h0);
    end
    check("reset_wb_we", {31'b0, wb_we}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    check_en = 1'b1;

    // single ALU write to index 5
    reg_write = 1; dest = 5; mem_to_reg = 0; alu = 32'hDEADBEEF; rs = 5;
    tick();
    check("w5_wb_data", wb_data, 32'hDEADBEEF);
    check("w5_wb_we", {31'b0, wb_we}, 32'h1);
    check("w5_wb_dest", {27'b0, wb_dest}, 32'd5);
    reg_write = 0;
    tick();
    check("w5_read_rs", rs_data, 32'hDEADBEEF);

    // write to index 0 is suppressed
    reg_write = 1; dest = 0; alu = 32'h12345678; rs = 0;
    tick();
    reg_write = 0;
    check("w0_wb_we", {31'b0, wb_we}, 32'h0);
    check("w0_read_rs", rs_data, 32'h0);
    tick();
    check("w0_read_rs_late", rs_data, 32'h0);

    // load-data write to 9, read during the WB cycle
    reg_write = 1; mem_to_reg = 1; mem = 32'hCAFEF00D; alu = 32'h5555AAAA; dest = 9; rt = 9;
    tick();
    reg_write = 0; mem_to_reg = 0;
    check("w9_rt_same_cycle", rt_data, BYPASS ? 32'hCAFEF00D : 32'h0);
    tick();
    check("w9_rt_next", rt_data, 32'hCAFEF00D);

    // reset during a pending writeback to index 3
    reg_write = 1; dest = 3; alu = 32'h11; rs = 3;
    tick();
    reg_write = 0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_wb_we", {31'b0, wb_we}, 32'h0);
    check("rst_wb_dest", {27'b0, wb_dest}, 32'h0);
    check("rst_wb_data", wb_data, 32'h0);
    check("rst_rs3", rs_data, 32'h0);
    check("rst_w9_cleared", rt_data, 32'h0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    tick();
    tick();
    check("rst_rs3_after", rs_data, 32'h0);

    // back-to-back writes to index 31
    reg_write = 1; dest = 31; alu = 32'hA; rs = 31;
    tick();
    alu = 32'hB;
    tick();
    reg_write = 0;
    check("w31_first", rs_data, BYPASS ? 32'hB : 32'hA);
    tick();
    check("w31_final", rs_data, 32'hB);

    // randomized traffic with occasional mid-cycle resets
    for (int c = 0; c < 3000; c++) begin
      reg_write  = ($urandom_range(0, 3) != 0);
      mem_to_reg = $urandom_range(0, 1);
      dest       = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
      alu        = $urandom;
      mem        = $urandom;
      rs         = ($urandom_range(0, 2) == 0) ? wb_dest : AW'($urandom);
      rt         = ($urandom_range(0, 2) == 0) ? rs : AW'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      tick();
    end

    // every entry visible on both ports
    reg_write = 0;
    for (int i = 0; i < N; i++) begin
      rs = i[AW-1:0];
      rt = i[AW-1:0];
      #1;
      v = exp_rd(rs);
      check("final_rs", rs_data, v);
      check("final_rt", rt_data, v);
    end
    check_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "timeout");
  end
endmodule
